// File: rtl/sequencia_jogo_n.sv
// Sequence-memory game: plays a growing sequence on the LEDs, then checks the player's presses against it.
// Optional per-move timeout is built only when SEQUENCIA_TIMEOUT_EN is defined.
module sequencia_jogo_n #(
   parameter int N_BOTOES  = 4,
   parameter int PROF      = 16,
   parameter int T_MOSTRA  = 5000,
   parameter int T_APAGA   = 1250,
   parameter int T_TIMEOUT = 15000,
   localparam int W        = $clog2(PROF)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                iniciar,
   input  logic [N_BOTOES-1:0] botoes,
   input  logic                escreve,
   input  logic [W-1:0]        end_escrita,
   input  logic [N_BOTOES-1:0] dado_escrita,
   output logic [N_BOTOES-1:0] leds,
   output logic                pronto,
   output logic                acertou,
   output logic                errou,
   output logic                timeout,
   output logic [W-1:0]        rodada,
   output logic [3:0]          db_estado
);

   localparam int T_MAX_A = (T_MOSTRA > T_APAGA) ? T_MOSTRA : T_APAGA;
   localparam int T_MAX   = (T_TIMEOUT > T_MAX_A) ? T_TIMEOUT : T_MAX_A;
   localparam int TW      = $clog2(T_MAX + 1);

   typedef enum logic [3:0] {
      IDLE           = 4'd0,
      MOSTRA_ACESO   = 4'd1,
      MOSTRA_APAGADO = 4'd2,
      ESPERA         = 4'd3,
      COMPARA        = 4'd4,
      FIM_ACERTO     = 4'd5,
      FIM_ERRO       = 4'd6,
      FIM_TIMEOUT    = 4'd7
   } estado_t;

   estado_t             state_q, state_d;
   logic [W-1:0]        rodada_q, rodada_d;
   logic [W-1:0]        end_q, end_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [N_BOTOES-1:0] press_q, press_d;
   logic [N_BOTOES-1:0] rd_q, rd_d;
   logic                prev_q, prev_d;
   logic                pronto_q, pronto_d;
   logic                acertou_q, acertou_d;
   logic                errou_q, errou_d;
`ifdef SEQUENCIA_TIMEOUT_EN
   logic                timeout_q, timeout_d;
`endif
   logic [N_BOTOES-1:0] mem [PROF];
   logic                mem_we;
   logic                any_botao;
   logic                move;

   // The read register always holds mem[end_q]: it is loaded with the next address every cycle.
   assign mem_we = escreve && (state_q == IDLE) && !reset;
   assign rd_d   = (mem_we && (end_escrita == end_d)) ? dado_escrita : mem[end_d];

   always_ff @(posedge clock) begin
      if (mem_we) mem[end_escrita] <= dado_escrita;
      rd_q <= rd_d;
   end

   always_comb begin
      any_botao = |botoes;
      move      = any_botao && !prev_q;
      state_d   = state_q;
      rodada_d  = rodada_q;
      end_d     = end_q;
      timer_d   = timer_q;
      press_d   = press_q;
      case (state_q)
         IDLE, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
            if (iniciar) begin
               state_d  = MOSTRA_ACESO;
               rodada_d = '0;
               end_d    = '0;
               timer_d  = '0;
            end
         end
         MOSTRA_ACESO: begin
            if (timer_q == TW'(T_MOSTRA - 1)) begin
               timer_d = '0;
               state_d = MOSTRA_APAGADO;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         MOSTRA_APAGADO: begin
            if (timer_q == TW'(T_APAGA - 1)) begin
               timer_d = '0;
               if (end_q == rodada_q) begin
                  end_d   = '0;
                  state_d = ESPERA;
               end else begin
                  end_d   = end_q + 1'b1;
                  state_d = MOSTRA_ACESO;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         // A move in the last allowed cycle takes priority over the timeout.
         ESPERA: begin
            if (move) begin
               press_d = botoes;
               timer_d = '0;
               state_d = COMPARA;
            end
`ifdef SEQUENCIA_TIMEOUT_EN
            else if (timer_q == TW'(T_TIMEOUT - 1)) begin
               state_d = FIM_TIMEOUT;
            end else begin
               timer_d = timer_q + 1'b1;
            end
`endif
         end
         COMPARA: begin
            timer_d = '0;
            if (press_q != rd_q) begin
               state_d = FIM_ERRO;
            end else if (end_q != rodada_q) begin
               end_d   = end_q + 1'b1;
               state_d = ESPERA;
            end else if (rodada_q == W'(PROF - 1)) begin
               state_d = FIM_ACERTO;
            end else begin
               rodada_d = rodada_q + 1'b1;
               end_d    = '0;
               state_d  = MOSTRA_ACESO;
            end
         end
         default: state_d = IDLE;
      endcase
      // Priming on ESPERA entry keeps a button held from before from counting as a move.
      prev_d    = ((state_d == ESPERA) && (state_q != ESPERA)) ? 1'b1 : any_botao;
      pronto_d  = (state_d == FIM_ACERTO) || (state_d == FIM_ERRO) || (state_d == FIM_TIMEOUT);
      acertou_d = (state_d == FIM_ACERTO);
      errou_d   = (state_d == FIM_ERRO);
`ifdef SEQUENCIA_TIMEOUT_EN
      timeout_d = (state_d == FIM_TIMEOUT);
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         rodada_q  <= '0;
         end_q     <= '0;
         timer_q   <= '0;
         press_q   <= '0;
         prev_q    <= 1'b1;
         pronto_q  <= 1'b0;
         acertou_q <= 1'b0;
         errou_q   <= 1'b0;
`ifdef SEQUENCIA_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         rodada_q  <= rodada_d;
         end_q     <= end_d;
         timer_q   <= timer_d;
         press_q   <= press_d;
         prev_q    <= prev_d;
         pronto_q  <= pronto_d;
         acertou_q <= acertou_d;
         errou_q   <= errou_d;
`ifdef SEQUENCIA_TIMEOUT_EN
         timeout_q <= timeout_d;
`endif
      end
   end

   always_comb begin
      leds = '0;
      if (state_q == MOSTRA_ACESO) leds = rd_q;
      else if (state_q == ESPERA) leds = botoes;
   end

   assign pronto    = pronto_q;
   assign acertou   = acertou_q;
   assign errou     = errou_q;
`ifdef SEQUENCIA_TIMEOUT_EN
   assign timeout   = timeout_q;
`else
   assign timeout   = 1'b0;
`endif
   assign rodada    = rodada_q;
   assign db_estado = state_q;

endmodule
